// File: rtl/media_arbiter_if.sv
// rtl/media_arbiter_if.sv - requester and averager signal bundle for media_arbiter
interface media_arbiter_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       valid0;
    logic       valid1;
    logic       grant0;
    logic       grant1;
    logic       done0;
    logic       done1;
    logic [7:0] result;
    logic       err;
    logic       m_start;
    logic       m_valid;
    logic [7:0] m_data;
    logic [7:0] m_media;
    logic       m_done;

    modport master (
        output req0, req1, data0, data1, valid0, valid1, m_media, m_done,
        input  grant0, grant1, done0, done1, result, err, m_start, m_valid, m_data
    );

    modport slave (
        input  req0, req1, data0, data1, valid0, valid1, m_media, m_done,
        output grant0, grant1, done0, done1, result, err, m_start, m_valid, m_data
    );
endinterface

// File: rtl/media_arbiter.sv
// rtl/media_arbiter.sv - round-robin arbiter giving two requesters turns on a shared averager
module media_arbiter #(
    parameter int NSAMP   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic     clk,
    input  logic     reset,
    media_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, FEED, WAIT, RESP} state_t;

    localparam logic [2:0] LAST_SAMP = 3'(NSAMP - 1);
    localparam logic [4:0] LAST_WAIT = 5'(TIMEOUT - 1);

    state_t     state_q;
    logic       last_q;
    logic       owner_q;
    logic [1:0] grant_q;
    logic [2:0] samp_q;
    logic [4:0] wait_q;
    logic       m_start_q;
    logic       m_valid_q;
    logic [7:0] m_data_q;
    logic [7:0] result_q;
    logic [1:0] done_q;
    logic       err_q;

    logic       winner_d;
    logic       req_g;
    logic       valid_g;
    logic [7:0] data_g;

    // Contention goes to whoever was not served last; otherwise the lone requester wins.
    always_comb begin
        winner_d = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        req_g    = owner_q ? bus.req1   : bus.req0;
        valid_g  = owner_q ? bus.valid1 : bus.valid0;
        data_g   = owner_q ? bus.data1  : bus.data0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            samp_q    <= 3'd0;
            wait_q    <= 5'd0;
            m_start_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'd0;
            result_q  <= 8'd0;
            done_q    <= 2'b00;
            err_q     <= 1'b0;
        end else begin
            m_start_q <= 1'b0;
            m_valid_q <= 1'b0;
            done_q    <= 2'b00;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        owner_q   <= winner_d;
                        grant_q   <= winner_d ? 2'b10 : 2'b01;
                        m_start_q <= 1'b1;
                        samp_q    <= 3'd0;
                        wait_q    <= 5'd0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (!req_g) begin
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end else begin
                        state_q <= FEED;
                    end
                end
                FEED: begin
                    if (!req_g) begin
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end else if (valid_g) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= data_g;
                        samp_q    <= samp_q + 3'd1;
                        if (samp_q == LAST_SAMP) begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A completion landing on the timeout cycle still counts as success.
                    if (!req_g) begin
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end else if (bus.m_done) begin
                        result_q <= bus.m_media;
                        done_q   <= grant_q;
                        state_q  <= RESP;
                    end else if (wait_q == LAST_WAIT) begin
                        result_q <= 8'd0;
                        err_q    <= 1'b1;
                        done_q   <= grant_q;
                        state_q  <= RESP;
                    end else begin
                        wait_q <= wait_q + 5'd1;
                    end
                end
                RESP: begin
                    grant_q <= 2'b00;
                    last_q  <= owner_q;
                    state_q <= IDLE;
                end
                default: begin
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant0  = grant_q[0];
    assign bus.grant1  = grant_q[1];
    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.err     = err_q;
    assign bus.result  = result_q;
    assign bus.m_start = m_start_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
endmodule

// File: tb/tb_media_arbiter.sv
// tb/tb_media_arbiter.sv - directed vector and sequence bench for media_arbiter
module tb_media_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    media_arbiter_if bus ();

    media_arbiter #(.NSAMP(4), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        v0;
        logic [7:0]  d0;
        logic        v1;
        logic [7:0]  d1;
        logic        md;
        logic [7:0]  mm;
        logic [14:0] exp_o;
        logic [7:0]  exp_mdata;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input int r0, input int r1, input int v0, input int d0,
                                input int v1, input int d1, input int md, input int mm,
                                input int g0, input int g1, input int ms, input int mv,
                                input int mdat, input int dn0, input int dn1, input int er,
                                input int res);
        vec_t v;
        v.r0        = 1'(r0);
        v.r1        = 1'(r1);
        v.v0        = 1'(v0);
        v.d0        = 8'(d0);
        v.v1        = 1'(v1);
        v.d1        = 8'(d1);
        v.md        = 1'(md);
        v.mm        = 8'(mm);
        v.exp_o     = {1'(g0), 1'(g1), 1'(ms), 1'(mv), 1'(dn0), 1'(dn1), 1'(er), 8'(res)};
        v.exp_mdata = 8'(mdat);
        return v;
    endfunction

    function automatic logic [14:0] outs();
        return {bus.grant0, bus.grant1, bus.m_start, bus.m_valid,
                bus.done0, bus.done1, bus.err, bus.result};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.valid0 = 1'b0; bus.valid1 = 1'b0;
        bus.data0 = 8'd0; bus.data1 = 8'd0;
        bus.m_done = 1'b0; bus.m_media = 8'd0;
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) bus.req0 = v;
        else          bus.req1 = v;
    endtask

    task automatic set_valid(input int who, input logic v, input logic [7:0] d);
        if (who == 0) begin bus.valid0 = v; bus.data0 = d; end
        else          begin bus.valid1 = v; bus.data1 = d; end
    endtask

    function automatic logic [1:0] gvec(input int who);
        return (who == 0) ? 2'b01 : 2'b10;
    endfunction

    // From IDLE with the request already raised: START, FEED, then four forwarded samples.
    task automatic start_feed(input int who, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        logic [7:0] s [4];
        s = '{a, b, c, d};
        tick();
        chk("start_grant", 32'({bus.grant1, bus.grant0}), 32'(gvec(who)));
        chk("start_mstart", 32'(bus.m_start), 32'd1);
        tick();
        chk("feed_mstart_low", 32'(bus.m_start), 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_valid(who, 1'b1, s[i]);
            tick();
            chk("feed_mvalid", 32'(bus.m_valid), 32'd1);
            chk("feed_mdata", 32'(bus.m_data), 32'(s[i]));
        end
        set_valid(who, 1'b0, 8'd0);
    endtask

    task automatic finish_wait(input int who, input logic [7:0] avg);
        bus.m_done = 1'b1;
        bus.m_media = avg;
        tick();
        bus.m_done = 1'b0;
        chk("resp_done", 32'({bus.done1, bus.done0}), 32'(gvec(who)));
        chk("resp_result", 32'(bus.result), 32'(avg));
        chk("resp_err", 32'(bus.err), 32'd0);
        set_req(who, 1'b0);
        tick();
        chk("post_grant", 32'({bus.grant1, bus.grant0}), 32'd0);
        chk("post_done", 32'({bus.done1, bus.done0}), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dn;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        clr_inputs();

        tick();
        tick();
        chk("reset_outputs", 32'(outs()), 32'd0);
        chk("reset_mdata", 32'(bus.m_data), 32'd0);
        reset = 1'b1;
        tick();

        // r0 r1 v0 d0 v1 d1 md mm | g0 g1 ms mv mdata dn0 dn1 er res
        tbl[0]  = mk(1, 0, 0,   0, 0,  0, 0,   0,  1, 0, 1, 0,  0, 0, 0, 0,  0);
        tbl[1]  = mk(1, 0, 1,  99, 0,  0, 0,   0,  1, 0, 0, 0,  0, 0, 0, 0,  0);
        tbl[2]  = mk(1, 0, 1,  24, 0,  0, 0,   0,  1, 0, 0, 1, 24, 0, 0, 0,  0);
        tbl[3]  = mk(1, 0, 0,   0, 1, 77, 1, 123,  1, 0, 0, 0,  0, 0, 0, 0,  0);
        tbl[4]  = mk(1, 0, 1,  32, 0,  0, 0,   0,  1, 0, 0, 1, 32, 0, 0, 0,  0);
        tbl[5]  = mk(1, 0, 1,  10, 1, 55, 0,   0,  1, 0, 0, 1, 10, 0, 0, 0,  0);
        tbl[6]  = mk(1, 0, 1,  14, 0,  0, 0,   0,  1, 0, 0, 1, 14, 0, 0, 0,  0);
        tbl[7]  = mk(1, 0, 1, 200, 1, 66, 0,   0,  1, 0, 0, 0,  0, 0, 0, 0,  0);
        tbl[8]  = mk(1, 0, 0,   0, 0,  0, 1,  20,  1, 0, 0, 0,  0, 1, 0, 0, 20);
        tbl[9]  = mk(0, 0, 0,   0, 0,  0, 0,   0,  0, 0, 0, 0,  0, 0, 0, 0, 20);
        tbl[10] = mk(0, 0, 0,   0, 0,  0, 1,  99,  0, 0, 0, 0,  0, 0, 0, 0, 20);

        for (int i = 0; i < 11; i++) begin
            bus.req0 = tbl[i].r0;  bus.req1 = tbl[i].r1;
            bus.valid0 = tbl[i].v0; bus.data0 = tbl[i].d0;
            bus.valid1 = tbl[i].v1; bus.data1 = tbl[i].d1;
            bus.m_done = tbl[i].md; bus.m_media = tbl[i].mm;
            tick();
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp_o));
            if (tbl[i].exp_o[11])
                chk($sformatf("vec%0d_mdata", i), 32'(bus.m_data), 32'(tbl[i].exp_mdata));
        end
        clr_inputs();

        // Round robin from a fresh reset: 0, then 1, then 0 again under contention.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        start_feed(0, 8'd1, 8'd2, 8'd3, 8'd4);
        finish_wait(0, 8'd3);
        start_feed(1, 8'd5, 8'd6, 8'd7, 8'd8);
        finish_wait(1, 8'd6);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        start_feed(0, 8'd9, 8'd9, 8'd9, 8'd9);
        finish_wait(0, 8'd9);
        bus.req1 = 1'b0;
        tick();
        chk("rr_idle_grant", 32'({bus.grant1, bus.grant0}), 32'd0);

        // Averager never answers: sixteen WAIT cycles then error response.
        bus.req0 = 1'b1;
        start_feed(0, 8'd40, 8'd41, 8'd42, 8'd43);
        n = 0;
        while (n < 40 && !bus.done0) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("timeout_err", 32'(bus.err), 32'd1);
        chk("timeout_result", 32'(bus.result), 32'd0);
        chk("timeout_grant", 32'({bus.grant1, bus.grant0}), 32'b01);
        bus.req0 = 1'b0;
        tick();
        chk("timeout_err_pulse", 32'(bus.err), 32'd0);

        // Completion on the very cycle of the limit wins over the timeout.
        bus.req0 = 1'b1;
        start_feed(0, 8'd1, 8'd1, 8'd1, 8'd1);
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done0 || bus.err) dn++;
        end
        chk("edge_no_early_done", 32'(dn), 32'd0);
        finish_wait(0, 8'd77);

        // Requester 1 gives up after two samples, then retries from scratch.
        bus.req1 = 1'b1;
        tick();
        chk("abort_start", 32'({bus.grant1, bus.grant0, bus.m_start}), 32'b101);
        tick();
        set_valid(1, 1'b1, 8'd11);
        tick();
        set_valid(1, 1'b1, 8'd12);
        tick();
        chk("abort_two_samples", 32'({bus.m_valid, bus.m_data}), 32'h10c);
        set_valid(1, 1'b0, 8'd0);
        bus.req1 = 1'b0;
        tick();
        chk("abort_grant", 32'({bus.grant1, bus.grant0}), 32'd0);
        chk("abort_done", 32'({bus.done1, bus.done0}), 32'd0);
        tick();
        chk("abort_idle", 32'(outs() & 15'h7f00), 32'd0);
        bus.req1 = 1'b1;
        start_feed(1, 8'd21, 8'd22, 8'd23, 8'd24);
        finish_wait(1, 8'd22);

        // Asynchronous reset in the middle of FEED.
        bus.req0 = 1'b1;
        tick();
        tick();
        set_valid(0, 1'b1, 8'd55);
        tick();
        set_valid(0, 1'b0, 8'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'd0);
        chk("async_reset_mdata", 32'(bus.m_data), 32'd0);
        tick();
        chk("reset_held_outs", 32'(outs()), 32'd0);
        reset = 1'b1;
        start_feed(0, 8'd8, 8'd8, 8'd8, 8'd8);
        finish_wait(0, 8'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/media_arbiter.md
MEDIA_ARBITER -- requirements
Module: media_arbiter

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have the ports `req0`, `req1`, input, 1 bit each: a requester holds its line high until its `done0`/`done1` pulse.
REQ-004 The block SHALL have the ports `data0`, `data1`, input, 8 bits each: requester sample data.
REQ-005 The block SHALL have the ports `valid0`, `valid1`, input, 1 bit each: a requester sample strobe, with one sample per high cycle.
REQ-006 The block SHALL have the ports `grant0`, `grant1`, output, 1 bit each: requester owns the averager, one-hot or zero.
REQ-007 The block SHALL have the ports `done0`, `done1`, output, 1 bit each: a one-cycle pulse when `result` is valid for that requester.
REQ-008 The block SHALL have the port `result`, output, 8 bits: the last average returned.
REQ-009 The block SHALL have the port `err`, output, 1 bit: a one-cycle pulse coincident with `doneX` when the averager timed out.
REQ-010 The block SHALL have the ports `m_start`, `m_valid`, output, 1 bit each: start and sample strobe to the shared `media` averager.
REQ-011 The block SHALL have the port `m_data`, output, 8 bits: the sample to the averager.
REQ-012 The block SHALL have the ports `m_media`, input, 8 bits, and `m_done`, input, 1 bit: the averager result and its completion strobe.
REQ-013 The block SHALL have the parameter `NSAMP`, default 4: samples per average.
REQ-014 The block SHALL have the parameter `TIMEOUT`, default 16: the maximum number of cycles in WAIT.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, START, FEED, WAIT and RESP.
REQ-016 In IDLE with any `req` high, the FSM SHALL select a requester and go to START; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: when both `req` lines are high, the requester not served last SHALL win, and after reset `req0` SHALL win.
REQ-018 On entering START, the `grantX` of the winner SHALL rise and stay high through RESP.
REQ-019 START SHALL last one cycle with `m_start` = 1, then the FSM SHALL go to FEED.
REQ-020 In FEED, each `validX` of the granted requester SHALL produce, on the next cycle, `m_valid` = 1 and `m_data` = that `dataX` (1-cycle registered latency).
REQ-021 In FEED, `valid`/`data` of the non-granted requester SHALL be ignored.
REQ-022 A 3-bit sample counter SHALL count forwarded samples, and on the NSAMP-th sample the FSM SHALL go to WAIT.
REQ-023 Samples in excess of NSAMP SHALL be dropped.
REQ-024 In WAIT, `m_done` = 1 SHALL latch `m_media` into `result` and move the FSM to RESP.
REQ-025 A 5-bit counter SHALL count cycles in WAIT; when it reaches TIMEOUT with no `m_done`, `result` SHALL be set to 0, the `err` flag SHALL be set, and the FSM SHALL go to RESP.
REQ-026 RESP SHALL last one cycle, with `doneX` = 1 for the granted requester and `err` = 1 if flagged.
REQ-027 The cycle after RESP, `grantX` SHALL fall, the last-served pointer SHALL update, and the FSM SHALL return to IDLE.
REQ-028 If the granted `req` falls during START, FEED or WAIT, the block SHALL abort to IDLE the next cycle, drop grant, emit no `done`, and leave the pointer unchanged.
REQ-029 `m_done` outside WAIT SHALL be ignored.
REQ-030 `m_done` in the same cycle as the timeout limit SHALL take priority, with a valid result and `err` = 0.
REQ-031 `validX` in the same cycle as the START transition SHALL be ignored; sampling SHALL begin in FEED.
REQ-032 `m_start`, `m_valid`, `doneX` and `err` SHALL never be high for more than one consecutive cycle, except `m_valid` on back-to-back `valid` inputs.

Reset
REQ-033 While `reset` = 0, the state SHALL be IDLE, the last-served pointer SHALL indicate requester 1 (so `req0` wins first), and the counters SHALL be 0.
REQ-034 While `reset` = 0, all outputs SHALL be 0: `grant0`/`grant1`, `done0`/`done1`, `err`, `m_start`, `m_valid`, `m_data` = 0, `result` = 0.
REQ-035 Reset asserted mid-operation SHALL clear all state immediately (asynchronously) with no `done` pulse, and the next request SHALL restart from START.

Verification
REQ-036 The bench SHALL cover: `req0` only, samples 24, 32, 10, 14, averager returns 20 -> `grant0`, one `m_start`, four `m_valid` carrying 24, 32, 10, 14, `result` = 20, one `done0`, `err` = 0.
REQ-037 The bench SHALL cover: `req0` and `req1` raised in the same cycle after reset -> `req0` served first; `req1` granted on the next IDLE exit; a third round with both high -> `req0` again.
REQ-038 The bench SHALL cover: `valid1` pulsed while `grant0` is high -> no `m_valid` for those pulses, and the sample count is unaffected.
REQ-039 The bench SHALL cover: `m_done` withheld -> after 16 WAIT cycles, `done0` = 1, `err` = 1, `result` = 0.
REQ-040 The bench SHALL cover: `req1` dropped after 2 samples -> grant drops next cycle, no `done1`, IDLE; the following `req1` gets a fresh `m_start`.
REQ-041 The bench SHALL cover: `reset` = 0 during FEED -> all outputs 0 immediately; after release, a full transaction averaging 8, 8, 8, 8 returns `result` = 8.
